mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr.sv | 23 ++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: sequencer states and the
// identity of the port that owns the shared memory port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    function automatic grant_t other_port(input grant_t g);
        return (g == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the port that did not win last time.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    output grant_t grant
);

    always_comb begin
        grant = last_grant;
        if (req_i && req_d) begin
            grant = other_port(last_grant);
        end else if (req_i) begin
            grant = GNT_INSTR;
        end else if (req_d) begin
            grant = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch port and a data port.
// Each access costs two cycles (issue, response) and can chain back-to-back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    output logic              instr_done,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] data_writedata,
    output logic [DATA_W-1:0] data_readdata,
    output logic              data_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    state_t            r_state;
    grant_t            r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_instr_done;
    logic              r_data_done;

    logic              w_in_resp;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_any_req;
    grant_t            w_grant;
    logic              w_grant_write;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_grant_wdata;

    // The port finishing in RESP still holds its request, so mask it out.
    assign w_in_resp = (r_state == RESP);
    assign w_req_i   = instr_read && !(w_in_resp && (r_last_grant == GNT_INSTR));
    assign w_req_d   = (data_read || data_write) &&
                       !(w_in_resp && (r_last_grant == GNT_DATA));
    assign w_any_req = w_req_i || w_req_d;

    mem_arb_rr u_rr (
        .req_i      (w_req_i),
        .req_d      (w_req_d),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    assign w_grant_write = (w_grant == GNT_DATA) && data_write;
    assign w_grant_addr  = (w_grant == GNT_DATA) ? data_address : instr_address;
    assign w_grant_wdata = (w_grant == GNT_DATA) ? data_writedata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_INSTR;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_instr_done <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_instr_done <= 1'b0;
            r_data_done  <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_any_req) begin
                        r_last_grant <= w_grant;
                        r_addr       <= w_grant_addr;
                        r_wdata      <= w_grant_wdata;
                        r_mem_read   <= !w_grant_write;
                        r_mem_write  <= w_grant_write;
                        r_state      <= ISSUE;
                    end else begin
                        r_state      <= IDLE;
                    end
                end
                ISSUE: begin
                    r_instr_done <= (r_last_grant == GNT_INSTR);
                    r_data_done  <= (r_last_grant == GNT_DATA);
                    r_state      <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset squashes strobes in the same cycle so an aborted access never completes.
    assign mem_read       = r_mem_read && !reset;
    assign mem_write      = r_mem_write && !reset;
    assign instr_done     = r_instr_done && !reset;
    assign data_done      = r_data_done && !reset;
    assign mem_address    = r_addr;
    assign mem_writedata  = r_wdata;
    assign instr_readdata = instr_done ? mem_readdata : '0;
    assign data_readdata  = data_done ? mem_readdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level scheduling model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_done;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        data_done;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [3:0]  ctrl;
    logic        memClear;
    logic [31:0] envMem [256];
    logic [31:0] refMem [256];
    int          testsRun;
    int          testsFailed;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_read     (instr_read),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .instr_done     (instr_done),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .data_done      (data_done),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    assign ctrl = {instr_done, data_done, mem_read, mem_write};

    function automatic logic [31:0] memInit(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'hDEADBEEF : {8'hA5, idx, 8'h00, idx ^ 8'h3C};
    endfunction

    // Memory behind the shared port: read data appears one cycle after mem_read.
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 256; i++) envMem[i] <= memInit(8'(i));
            mem_readdata <= 32'h0;
        end else begin
            if (mem_write) envMem[mem_address[9:2]] <= mem_writedata;
            if (mem_read) mem_readdata <= envMem[mem_address[9:2]];
            else          mem_readdata <= 32'h0BAD0BAD;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        instr_read     = 1'b0;
        instr_address  = 32'h0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_address   = 32'h0;
        data_writedata = 32'h0;
    endtask

    task automatic applyReset();
        nextCycle();
        idleInputs();
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nextCycle();
        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 0000", ctrl);
        end
        testsRun++;
        if (instr_readdata !== 32'h0 || data_readdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_rdata: got %h/%h, expected 0/0", instr_readdata, data_readdata);
        end
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0000 || instr_readdata !== 32'h0 || data_readdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset: ctrl %b rdata %h/%h, expected 0000 0/0",
                     ctrl, instr_readdata, data_readdata);
        end
    endtask

    task automatic test_single_fetch();
        nextCycle();
        instr_read    = 1'b1;
        instr_address = 32'h10;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL fetch_n: got %b, expected 0000", ctrl);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0010 || mem_address !== 32'h10) begin
            testsFailed++;
            $display("[TB] FAIL fetch_issue: ctrl %b addr %h, expected 0010 00000010", ctrl, mem_address);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b1000 || instr_readdata !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL fetch_done: ctrl %b rdata %h, expected 1000 deadbeef", ctrl, instr_readdata);
        end
        nextCycle();
        instr_read = 1'b0;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL fetch_after: got %b, expected 0000", ctrl);
        end
    endtask

    task automatic test_single_write();
        nextCycle();
        data_write     = 1'b1;
        data_address   = 32'h100;
        data_writedata = 32'h12345678;
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0001 || mem_address !== 32'h100 || mem_writedata !== 32'h12345678) begin
            testsFailed++;
            $display("[TB] FAIL write_issue: ctrl %b addr %h wdata %h, expected 0001 00000100 12345678",
                     ctrl, mem_address, mem_writedata);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL write_done: got %b, expected 0100", ctrl);
        end
        nextCycle();
        data_write = 1'b0;
        data_read  = 1'b1;
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0010 || mem_address !== 32'h100) begin
            testsFailed++;
            $display("[TB] FAIL readback_issue: ctrl %b addr %h, expected 0010 00000100", ctrl, mem_address);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0100 || data_readdata !== 32'h12345678) begin
            testsFailed++;
            $display("[TB] FAIL readback_done: ctrl %b rdata %h, expected 0100 12345678", ctrl, data_readdata);
        end
        nextCycle();
        data_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int nInstr = 0;
        int nData  = 0;
        logic [31:0] expAddr;
        applyReset();
        nextCycle();
        instr_read    = 1'b1;
        instr_address = 32'h10;
        data_read     = 1'b1;
        data_address  = 32'h100;
        for (int k = 1; k <= 100; k++) begin
            nextCycle();
            if (k == 99) data_read = 1'b0;
            @(negedge clk);
            if (instr_done === 1'b1) nInstr++;
            if (data_done === 1'b1) nData++;
            testsRun++;
            if (k % 2 == 1) begin
                expAddr = (k % 4 == 1) ? 32'h100 : 32'h10;
                if (ctrl !== 4'b0010 || mem_address !== expAddr) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_issue k=%0d: ctrl %b addr %h, expected 0010 %h",
                             k, ctrl, mem_address, expAddr);
                end
            end else if (k % 4 == 2) begin
                if (ctrl !== 4'b0100 || data_readdata !== 32'h12345678) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_data k=%0d: ctrl %b rdata %h, expected 0100 12345678",
                             k, ctrl, data_readdata);
                end
            end else begin
                if (ctrl !== 4'b1000 || instr_readdata !== 32'hDEADBEEF) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_instr k=%0d: ctrl %b rdata %h, expected 1000 deadbeef",
                             k, ctrl, instr_readdata);
                end
            end
        end
        testsRun++;
        if (nInstr != 25 || nData != 25) begin
            testsFailed++;
            $display("[TB] FAIL b2b_counts: instr %0d data %0d, expected 25 25", nInstr, nData);
        end
        nextCycle();
        instr_read = 1'b0;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL b2b_drain: got %b, expected 0000", ctrl);
        end
    endtask

    task automatic test_tie_rotation();
        nextCycle();
        data_read    = 1'b1;
        data_address = 32'h100;
        nextCycle();
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL lone_data_done: got %b, expected 0100", ctrl);
        end
        nextCycle();
        data_read = 1'b0;
        nextCycle();
        instr_read    = 1'b1;
        instr_address = 32'h10;
        data_read     = 1'b1;
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0010 || mem_address !== 32'h10) begin
            testsFailed++;
            $display("[TB] FAIL tie_instr_first: ctrl %b addr %h, expected 0010 00000010", ctrl, mem_address);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL tie_instr_done: got %b, expected 1000", ctrl);
        end
        nextCycle();
        instr_read = 1'b0;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0010 || mem_address !== 32'h100) begin
            testsFailed++;
            $display("[TB] FAIL tie_data_second: ctrl %b addr %h, expected 0010 00000100", ctrl, mem_address);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL tie_data_done: got %b, expected 0100", ctrl);
        end
        nextCycle();
        data_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_write_both();
        int nDone = 0;
        nextCycle();
        data_read      = 1'b1;
        data_write     = 1'b1;
        data_address   = 32'h200;
        data_writedata = 32'hCAFEF00D;
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            if (k == 3) begin
                data_read  = 1'b0;
                data_write = 1'b0;
            end
            @(negedge clk);
            if (data_done === 1'b1) nDone++;
            if (k == 1) begin
                testsRun++;
                if (ctrl !== 4'b0001 || mem_writedata !== 32'hCAFEF00D) begin
                    testsFailed++;
                    $display("[TB] FAIL rw_issue: ctrl %b wdata %h, expected 0001 cafef00d", ctrl, mem_writedata);
                end
            end
        end
        testsRun++;
        if (nDone != 1) begin
            testsFailed++;
            $display("[TB] FAIL rw_done_count: got %0d, expected 1", nDone);
        end
    endtask

    task automatic test_reset_abort();
        nextCycle();
        instr_read    = 1'b1;
        instr_address = 32'h10;
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL abort_issue: got %b, expected 0000", ctrl);
        end
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL abort_no_done: got %b, expected 0000", ctrl);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b0010 || mem_address !== 32'h10) begin
            testsFailed++;
            $display("[TB] FAIL abort_reissue: ctrl %b addr %h, expected 0010 00000010", ctrl, mem_address);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (ctrl !== 4'b1000 || instr_readdata !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL abort_done: ctrl %b rdata %h, expected 1000 deadbeef", ctrl, instr_readdata);
        end
        nextCycle();
        instr_read = 1'b0;
        @(negedge clk);
    endtask

    // Transaction-level model: a grant at cycle c accesses memory at c+1 and
    // completes at c+2; arbitration is possible whenever no access is being issued.
    task automatic test_random();
        int busyUntil = -10;
        int accCycle  = -10;
        int curPort   = 0;
        int lastGrant = 0;
        logic accWrite = 1'b0;
        logic [31:0] accAddr = 32'h0;
        logic [31:0] accWData = 32'h0;
        logic [31:0] accRData = 32'h0;
        logic pI = 1'b0;
        logic pD = 1'b0;
        int dKind = 0;
        logic [31:0] iAddr = 32'h0;
        logic [31:0] dAddr = 32'h0;
        logic [31:0] dWData = 32'h0;
        logic rst;
        logic rI;
        logic rD;
        logic doneNow;
        int g;
        logic [3:0] expCtrl;
        for (int i = 0; i < 256; i++) refMem[i] = memInit(8'(i));
        applyReset();
        for (int c = 0; c < 600; c++) begin
            nextCycle();
            if (!pI && $urandom_range(0, 2) == 0) begin
                pI    = 1'b1;
                iAddr = 32'h300 + ($urandom_range(0, 15) << 2);
            end
            if (!pD && $urandom_range(0, 2) == 0) begin
                pD     = 1'b1;
                dKind  = int'($urandom_range(0, 2));
                dAddr  = 32'h300 + ($urandom_range(0, 15) << 2);
                dWData = $urandom;
            end
            rst            = ($urandom_range(0, 39) == 0);
            reset          = rst;
            instr_read     = pI;
            instr_address  = pI ? iAddr : $urandom;
            data_read      = pD && (dKind != 1);
            data_write     = pD && (dKind != 0);
            data_address   = pD ? dAddr : $urandom;
            data_writedata = pD ? dWData : $urandom;
            @(negedge clk);
            expCtrl = 4'b0000;
            if (!rst) begin
                if (accCycle == c) begin
                    expCtrl[1:0] = accWrite ? 2'b01 : 2'b10;
                    if (accWrite) refMem[accAddr[9:2]] = accWData;
                    else          accRData = refMem[accAddr[9:2]];
                end
                if (busyUntil == c) expCtrl[3:2] = (curPort == 0) ? 2'b10 : 2'b01;
            end
            testsRun++;
            if (ctrl !== expCtrl) begin
                testsFailed++;
                $display("[TB] FAIL rand_ctrl c=%0d: got %b, expected %b", c, ctrl, expCtrl);
            end
            if (expCtrl[1:0] != 2'b00) begin
                testsRun++;
                if (mem_address !== accAddr || (accWrite && mem_writedata !== accWData)) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_access c=%0d: addr %h wdata %h, expected %h %h",
                             c, mem_address, mem_writedata, accAddr, accWData);
                end
            end
            if (expCtrl[3]) begin
                testsRun++;
                if (instr_readdata !== accRData) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_irdata c=%0d: got %h, expected %h", c, instr_readdata, accRData);
                end
            end
            if (expCtrl[2] && !accWrite) begin
                testsRun++;
                if (data_readdata !== accRData) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_drdata c=%0d: got %h, expected %h", c, data_readdata, accRData);
                end
            end
            if (rst) begin
                busyUntil = -10;
                accCycle  = -10;
                lastGrant = 0;
            end else begin
                doneNow = (busyUntil == c);
                if (doneNow) begin
                    if (curPort == 0) pI = 1'b0;
                    else              pD = 1'b0;
                end
                if (c != busyUntil - 1) begin
                    rI = instr_read && !(doneNow && curPort == 0);
                    rD = (data_read || data_write) && !(doneNow && curPort == 1);
                    if (rI || rD) begin
                        g = (rI && rD) ? (1 - lastGrant) : (rI ? 0 : 1);
                        lastGrant = g;
                        curPort   = g;
                        accCycle  = c + 1;
                        busyUntil = c + 2;
                        if (g == 0) begin
                            accWrite = 1'b0;
                            accAddr  = iAddr;
                        end else begin
                            accWrite = (dKind != 0);
                            accAddr  = dAddr;
                            accWData = dWData;
                        end
                    end
                end
            end
        end
        nextCycle();
        idleInputs();
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        idleInputs();
        reset    = 1'b1;
        memClear = 1'b1;
        @(posedge clk);
        #1;
        memClear = 1'b0;
        test_reset();
        test_single_fetch();
        test_single_write();
        test_back_to_back();
        test_tie_rotation();
        test_read_write_both();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
